// File: rtl/button_bank_debouncer_pkg.sv
// Shared types and helpers for the button bank debouncer.
package button_pkg;

    // Per-channel press-tracking state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2,
        LATCHED = 2'd3
    } btn_state_t;

    // Bits needed to hold a counter value 0..max_val, never narrower than 1.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_bank_debouncer_if.sv
// Button pins in, per-channel clean level and strobes out.
interface button_bank_debouncer_if #(
    parameter int NUM_BTNS = 5
);
    logic [NUM_BTNS-1:0] btn_in;
    logic [NUM_BTNS-1:0] btn_db;
    logic [NUM_BTNS-1:0] btn_pressed;
    logic [NUM_BTNS-1:0] btn_released;
    logic [NUM_BTNS-1:0] btn_long;
    logic [NUM_BTNS-1:0] btn_repeat;

    // Board / consumer side: drives the pins, watches the events.
    modport master (
        output btn_in,
        input  btn_db, btn_pressed, btn_released, btn_long, btn_repeat
    );

    // Debouncer side.
    modport slave (
        input  btn_in,
        output btn_db, btn_pressed, btn_released, btn_long, btn_repeat
    );
endinterface

// File: rtl/button_bank_debouncer_channel.sv
// One button: synchroniser, stable-count debounce, hold/repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_pressed,
    output logic btn_released,
    output logic btn_long,
    output logic btn_repeat
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
    // With repeat disabled REPEAT is never entered, so this value is unused.
    localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES == 0) ? '0 : RW'(REPEAT_CYCLES - 1);
    localparam btn_state_t HELD_STATE   = (REPEAT_CYCLES == 0) ? LATCHED : REPEAT;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
    logic                   db_d, rise, fall;
    btn_state_t             state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [RW-1:0]          rep_q, rep_d;
    logic                   long_d, repeat_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability shift chain for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Debounce: flip the clean level after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        db_d      = btn_db;
        rise      = 1'b0;
        fall      = 1'b0;
        if (s == btn_db) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d = '0;
            db_d      = s;
            rise      = s;
            fall      = ~s;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Hold/repeat FSM; a release in this cycle always wins over a threshold.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rep_d    = rep_q;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    hold_d  = HW'(1);
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = HELD_STATE;
                    hold_d  = '0;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    rep_d   = '0;
                end else if (rep_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            LATCHED: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_q    <= '0;
            btn_db       <= 1'b0;
            state_q      <= IDLE;
            hold_q       <= '0;
            rep_q        <= '0;
            btn_pressed  <= 1'b0;
            btn_released <= 1'b0;
            btn_long     <= 1'b0;
            btn_repeat   <= 1'b0;
        end else begin
            deb_cnt_q    <= deb_cnt_d;
            btn_db       <= db_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            rep_q        <= rep_d;
            btn_pressed  <= rise;
            btn_released <= fall;
            btn_long     <= long_d;
            btn_repeat   <= repeat_d;
        end
    end
endmodule

// File: rtl/button_bank_debouncer.sv
// Bank of independent button channels packed onto one interface.
module button_bank_debouncer #(
    parameter int NUM_BTNS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 3
) (
    input logic                    clk,
    input logic                    reset,
    button_bank_debouncer_if.slave bus
);
    logic [NUM_BTNS-1:0] db_w, pressed_w, released_w, long_w, repeat_w;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (bus.btn_in[i]),
            .btn_db      (db_w[i]),
            .btn_pressed (pressed_w[i]),
            .btn_released(released_w[i]),
            .btn_long    (long_w[i]),
            .btn_repeat  (repeat_w[i])
        );
    end

    assign bus.btn_db       = db_w;
    assign bus.btn_pressed  = pressed_w;
    assign bus.btn_released = released_w;
    assign bus.btn_long     = long_w;
    assign bus.btn_repeat   = repeat_w;
endmodule
